// File: rtl/overlay_mixer.sv
// Overlay compositor: tracks raster position, pulls overlay pixels from a line FIFO inside a
// latched window, colour-keys them over the background and re-emits data/syncs 2 cycles later.
module overlay_mixer #(
    parameter int          WIDTH      = 1920,
    parameter int          HEIGHT     = 1080,
    parameter int          OV_W       = 256,
    parameter int          OV_H       = 256,
    parameter logic [23:0] KEY_COLOUR = 24'hFF00FF,
    parameter logic        V_POLARITY = 1'b1
) (
    input  logic        pixelClock,
    input  logic        reset,
    input  logic        deIn,
    input  logic        hsyncIn,
    input  logic        vsyncIn,
    input  logic [23:0] bgData,
    input  logic [11:0] ovX,
    input  logic [11:0] ovY,
    input  logic        ovEnable,
    input  logic [23:0] fifoData,
    input  logic        fifoEmpty,
    output logic        fifoRead,
    output logic        frameStart,
    output logic        underflow,
    output logic        DE,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic [23:0] data
);

    localparam logic [11:0] X_MAX  = 12'(WIDTH - OV_W);
    localparam logic [11:0] Y_MAX  = 12'(HEIGHT - OV_H);
    localparam logic [11:0] X_LAST = 12'(WIDTH - 1);
    localparam logic [11:0] Y_LAST = 12'(HEIGHT - 1);
    localparam logic [12:0] OV_W13 = 13'(OV_W);
    localparam logic [12:0] OV_H13 = 13'(OV_H);

    logic        vs_act;
    logic        vs_act_d;
    logic        fs_edge;
    logic        de_fall;
    logic        x_hit;
    logic        y_hit;
    logic        in_win;
    logic [11:0] x_count;
    logic [11:0] y_count;
    logic [11:0] ov_x_l;
    logic [11:0] ov_y_l;
    logic        ov_en_l;
    logic        armed;
    logic        de_d1;
    logic        hs_d1;
    logic        vs_d1;
    logic        rd1;
    logic [23:0] bg_d1;

    assign vs_act  = (vsyncIn == V_POLARITY);
    assign fs_edge = vs_act & ~vs_act_d;
    assign de_fall = de_d1 & ~deIn;

    // 13-bit upper bound so a window touching the last column cannot wrap
    assign x_hit = (x_count >= ov_x_l) && ({1'b0, x_count} < ({1'b0, ov_x_l} + OV_W13));
    assign y_hit = (y_count >= ov_y_l) && ({1'b0, y_count} < ({1'b0, ov_y_l} + OV_H13));

    assign in_win   = armed & ov_en_l & deIn & x_hit & y_hit;
    assign fifoRead = in_win & ~fifoEmpty;

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            vs_act_d   <= 1'b0;
            frameStart <= 1'b0;
            armed      <= 1'b0;
            ov_en_l    <= 1'b0;
            ov_x_l     <= 12'd0;
            ov_y_l     <= 12'd0;
            underflow  <= 1'b0;
        end else begin
            vs_act_d   <= vs_act;
            frameStart <= fs_edge;
            if (fs_edge) begin
                armed     <= 1'b1;
                ov_en_l   <= ovEnable;
                ov_x_l    <= (ovX > X_MAX) ? X_MAX : ovX;
                ov_y_l    <= (ovY > Y_MAX) ? Y_MAX : ovY;
                underflow <= 1'b0;
            end else if (in_win && fifoEmpty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Raster counters saturate so an over-running timing generator cannot wrap into the window
    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            x_count <= 12'd0;
            y_count <= 12'd0;
        end else begin
            if (deIn) begin
                if (x_count != X_LAST) begin
                    x_count <= x_count + 12'd1;
                end
            end else if (de_fall) begin
                x_count <= 12'd0;
            end

            if (fs_edge) begin
                y_count <= 12'd0;
            end else if (de_fall && (y_count != Y_LAST)) begin
                y_count <= y_count + 12'd1;
            end
        end
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            de_d1 <= 1'b0;
            hs_d1 <= 1'b0;
            vs_d1 <= 1'b0;
            bg_d1 <= 24'd0;
            rd1   <= 1'b0;
            DE    <= 1'b0;
            HSYNC <= 1'b0;
            VSYNC <= 1'b0;
            data  <= 24'd0;
        end else begin
            de_d1 <= deIn;
            hs_d1 <= hsyncIn;
            vs_d1 <= vsyncIn;
            bg_d1 <= bgData;
            rd1   <= fifoRead;
            DE    <= de_d1;
            HSYNC <= hs_d1;
            VSYNC <= vs_d1;
            if (!de_d1) begin
                data <= 24'd0;
            end else if (rd1 && (fifoData != KEY_COLOUR)) begin
                data <= fifoData;
            end else begin
                data <= bg_d1;
            end
        end
    end

endmodule

// File: doc/overlay_mixer.md
Name: overlay_mixer

Overview:
- Pixel-domain compositor between the HDMI timing generator and the HDMI transmitter data/sync pins.
- Tracks raster position from incoming DE/HSYNC/VSYNC and pulls overlay pixels (24-bit RGB) from a DDR-fed line FIFO inside a rectangular window.
- Colour-keys each overlay pixel over the background stream and re-emits data with syncs delay-matched.
- Sits directly downstream of the timing generator and the background pattern source.

Parameters:
- WIDTH, 1920, active pixels per line.
- HEIGHT, 1080, active lines per frame.
- OV_W, 256, overlay width in pixels.
- OV_H, 256, overlay height in lines.
- KEY_COLOUR, 24'hFF00FF, overlay pixel value treated as transparent.
- V_POLARITY, 1, VSYNC active level (1 = active high).

Ports:
- pixelClock  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- deIn  in  1  data enable from timing generator.
- hsyncIn  in  1  horizontal sync from timing generator.
- vsyncIn  in  1  vertical sync from timing generator.
- bgData  in  24  background RGB, aligned with deIn.
- ovX  in  12  overlay left column; sampled at frame start.
- ovY  in  12  overlay top line; sampled at frame start.
- ovEnable  in  1  overlay enable; sampled at frame start.
- fifoData  in  24  overlay pixel; valid the cycle after fifoRead (non-show-ahead).
- fifoEmpty  in  1  FIFO empty flag.
- fifoRead  out  1  FIFO read strobe.
- frameStart  out  1  one-cycle pulse telling the DDR reader to restart at image base.
- underflow  out  1  sticky: a window pixel found the FIFO empty this frame.
- DE  out  1  delayed data enable.
- HSYNC  out  1  delayed horizontal sync.
- VSYNC  out  1  delayed vertical sync.
- data  out  24  composited RGB.

Behaviour:
- Reset: all outputs 0, counters 0, armed = 0, latched window = 0.
- Frame start is the vsyncIn transition to the V_POLARITY level, detected by a registered edge detector.
  - frameStart pulses 1 cycle in the cycle after that edge.
  - ovX, ovY and ovEnable are latched; armed is set; underflow is cleared.
  - ovX is clamped to WIDTH-OV_W if ovX > WIDTH-OV_W; ovY is clamped to HEIGHT-OV_H likewise.
- Raster counters:
  - xCount increments on each deIn=1 cycle; it clears to 0 on the deIn falling edge.
  - yCount increments on each deIn falling edge and clears to 0 at frame start.
  - Both are 12 bits. They saturate at WIDTH-1 / HEIGHT-1 if the timing generator over-runs.
- Window: inWin = armed & ovEnable_l & deIn & xCount in [ovX_l, ovX_l+OV_W) & yCount in [ovY_l, ovY_l+OV_H).
- fifoRead = inWin & ~fifoEmpty (combinational). If inWin & fifoEmpty: no read, underflow is set, and that pixel shows background.
- Pipeline stage 1 registers: deIn, hsyncIn, vsyncIn, bgData, rd1 = fifoRead.
- Pipeline stage 2:
  - data = (rd1 & fifoData != KEY_COLOUR) ? fifoData : bgData_d1.
  - DE/HSYNC/VSYNC = stage-1 copies.
  - data is forced to 0 when the delayed DE = 0.
- Latency: every output is exactly 2 pixelClock cycles after its input; syncs and data stay mutually aligned.
- Behaviour after reset de-asserts mid-frame:
  - armed stays 0 until the next frame start; no fifoRead is issued.
  - data = background; syncs pass through with 2-cycle latency.
- ovX/ovY/ovEnable changes mid-frame have no effect until the next frame start.
- With no underflow, exactly OV_W*OV_H reads are issued per armed, enabled frame.
- Frame start coinciding with deIn=1 (malformed timing): the frame-start actions take priority; the counters still follow the DE rules.

Test Plan:
- WIDTH=16, HEIGHT=8, OV 4x2, ovX=3, ovY=2, FIFO never empty, no key hits -> fifoRead high on x=3..6 of lines 2..3 only; 8 reads/frame; data = FIFO values at those pixels, bgData elsewhere, 2-cycle latency.
- Same setup, FIFO supplies 24'hFF00FF for the 2nd pixel of each row -> data at x=4 equals bgData there; all others are overlay.
- ovX=14 (exceeds 16-4) -> clamped to 12; reads at x=12..15; ovY=7 -> clamped to 6.
- fifoEmpty forced high on line 2, x=5 -> no read that cycle, bg shown, underflow=1 until the next frameStart clears it.
- Reset asserted mid-frame then released -> outputs 0 during reset; no fifoRead until after the next VSYNC edge; frameStart pulse width is exactly 1 cycle.
- ovEnable=0 -> zero reads; data equals bgData delayed 2 cycles; DE/HSYNC/VSYNC equal the inputs delayed 2 cycles.
